// File: rtl/masked_hpc3_mul_pipe_pkg.sv
// Shared helpers for the pipelined HPC3 masked multiplier: randomness pair
// indexing, pipeline latency, slice widths and field reduction polynomials.
package masked_hpc3_mul_pipe_pkg;

  // One R/P element per unordered share pair; (i,j) and (j,i) share it so that
  // the P terms cancel when the output shares are recombined.
  function automatic int num_quad(input int num_shares);
    return num_shares * (num_shares - 1) / 2;
  endfunction

  function automatic int qindex(input int i, input int j, input int num_shares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * num_shares - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  function automatic int hpc3_latency(input int output_reg);
    return 1 + output_reg;
  endfunction

  function automatic int lane_width(input int num_shares, input int bit_width);
    return num_shares * bit_width;
  endfunction

  function automatic int rand_width(input int num_shares, input int bit_width);
    return num_quad(num_shares) * bit_width;
  endfunction

  // Low-order coefficients of the irreducible polynomial; x^bit_width is implied.
  function automatic logic [31:0] gf_poly(input int bit_width);
    case (bit_width)
      2:       return 32'h3;
      3:       return 32'h3;
      4:       return 32'h3;
      5:       return 32'h5;
      6:       return 32'h3;
      7:       return 32'h3;
      8:       return 32'h1B;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/masked_hpc3_mul_pipe_lane.sv
// One lane of the HPC3 gadget: S1 share-domain registers with enable and
// bubble clear, the registered cross-product recombination, optional S2.
module masked_hpc3_mul_pipe_lane
  import masked_hpc3_mul_pipe_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 2,
  parameter int OUTPUT_REG = 0
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          load1,
  input  logic                                          valid1,
  input  logic                                          load2,
  input  logic                                          valid2,
  input  logic [lane_width(NUM_SHARES, BIT_WIDTH)-1:0] a,
  input  logic [lane_width(NUM_SHARES, BIT_WIDTH)-1:0] b,
  input  logic [rand_width(NUM_SHARES, BIT_WIDTH)-1:0] r,
  input  logic [rand_width(NUM_SHARES, BIT_WIDTH)-1:0] p,
  output logic [lane_width(NUM_SHARES, BIT_WIDTH)-1:0] c
);

  localparam int LW        = lane_width(NUM_SHARES, BIT_WIDTH);
  localparam int NUM_PAIRS = NUM_SHARES * (NUM_SHARES - 1);
  localparam logic [BIT_WIDTH-1:0] RED = BIT_WIDTH'(gf_poly(BIT_WIDTH));

  function automatic int pair_index(input int i, input int j);
    return i * (NUM_SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  function automatic logic [BIT_WIDTH-1:0] generic_mul(input logic [BIT_WIDTH-1:0] x,
                                                       input logic [BIT_WIDTH-1:0] y);
    logic [BIT_WIDTH-1:0] acc;
    logic                 carry;
    acc = '0;
    for (int k = BIT_WIDTH - 1; k >= 0; k--) begin
      carry = acc[BIT_WIDTH-1];
      acc   = acc << 1;
      if (carry) acc = acc ^ RED;
      if (y[k])  acc = acc ^ x;
    end
    return acc;
  endfunction

  logic [LW-1:0]        a_q, b_q, c1;
  logic [BIT_WIDTH-1:0] v_d [NUM_PAIRS];
  logic [BIT_WIDTH-1:0] w_d [NUM_PAIRS];
  logic [BIT_WIDTH-1:0] v_q [NUM_PAIRS];
  logic [BIT_WIDTH-1:0] w_q [NUM_PAIRS];

  // Before S1 only B_j or A_i meets fresh randomness; A_i never meets B_j.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_row
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_col
      if (i != j) begin : g_pair
        localparam int K = pair_index(i, j);
        localparam int Q = qindex(i, j, NUM_SHARES);
        assign v_d[K] = b[j*BIT_WIDTH +: BIT_WIDTH] ^ r[Q*BIT_WIDTH +: BIT_WIDTH];
        assign w_d[K] = generic_mul(a[i*BIT_WIDTH +: BIT_WIDTH], r[Q*BIT_WIDTH +: BIT_WIDTH])
                        ^ p[Q*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the V/W arrays are flops, not RAM, so they take the async reset
      // like any other register and leave no share residue after reset.
      a_q <= '0;
      b_q <= '0;
      v_q <= '{default: '0};
      w_q <= '{default: '0};
    end else if (load1) begin
      if (valid1) begin
        a_q <= a;
        b_q <= b;
        v_q <= v_d;
        w_q <= w_d;
      end else begin
        a_q <= '0;
        b_q <= '0;
        v_q <= '{default: '0};
        w_q <= '{default: '0};
      end
    end
  end

  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    logic [BIT_WIDTH-1:0] b_sum;
    logic [BIT_WIDTH-1:0] w_sum;
    // NOTE: both accumulators are assigned before the loop so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
      b_sum = b_q[i*BIT_WIDTH +: BIT_WIDTH];
      w_sum = '0;
      for (int j = 0; j < NUM_SHARES; j++) begin
        if (j != i) begin
          b_sum = b_sum ^ v_q[pair_index(i, j)];
          w_sum = w_sum ^ w_q[pair_index(i, j)];
        end
      end
    end
    assign c1[i*BIT_WIDTH +: BIT_WIDTH] = generic_mul(a_q[i*BIT_WIDTH +: BIT_WIDTH], b_sum) ^ w_sum;
  end

  if (OUTPUT_REG != 0) begin : g_s2
    logic [LW-1:0] c_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)      c_q <= '0;
      else if (load2) c_q <= valid2 ? c1 : '0;
    end
    assign c = c_q;
  end else begin : g_no_s2
    logic unused_s2;
    assign unused_s2 = load2 ^ valid2;
    assign c         = c1;
  end

endmodule

// File: rtl/masked_hpc3_mul_pipe.sv
// Multi-lane pipelined HPC3 masked GF(2^n) multiplier with valid/ready flow
// control; owns the stage valid bits, the ready chain and the lane array.
module masked_hpc3_mul_pipe
  import masked_hpc3_mul_pipe_pkg::*;
#(
  parameter int NUM_SHARES = 2,
  parameter int BIT_WIDTH  = 2,
  parameter int NUM_LANES  = 1,
  parameter int OUTPUT_REG = 0
) (
  input  logic                                                    in_clock,
  input  logic                                                    in_reset,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]               in_a,
  input  logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]               in_b,
  input  logic [NUM_LANES*num_quad(NUM_SHARES)*BIT_WIDTH-1:0]     in_r,
  input  logic [NUM_LANES*num_quad(NUM_SHARES)*BIT_WIDTH-1:0]     in_p,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [NUM_LANES*NUM_SHARES*BIT_WIDTH-1:0]               out_c
);

  localparam int LW = lane_width(NUM_SHARES, BIT_WIDTH);
  localparam int RW = rand_width(NUM_SHARES, BIT_WIDTH);

  logic v1;
  logic ready2;

  if (OUTPUT_REG != 0) begin : g_s2_ctrl
    logic v2;
    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset)    v2 <= 1'b0;
      else if (ready2) v2 <= v1;
    end
    assign ready2    = !v2 || out_ready;
    assign out_valid = v2;
  end else begin : g_s1_ctrl
    assign ready2    = out_ready;
    assign out_valid = v1;
  end

  // A full pipe still accepts when the consumer drains the tail this cycle.
  assign in_ready = !v1 || ready2;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset)      v1 <= 1'b0;
    else if (in_ready) v1 <= in_valid;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    masked_hpc3_mul_pipe_lane #(
      .NUM_SHARES(NUM_SHARES),
      .BIT_WIDTH (BIT_WIDTH),
      .OUTPUT_REG(OUTPUT_REG)
    ) u_lane (
      .clock (in_clock),
      .reset (in_reset),
      .load1 (in_ready),
      .valid1(in_valid),
      .load2 (ready2),
      .valid2(v1),
      .a     (in_a[l*LW +: LW]),
      .b     (in_b[l*LW +: LW]),
      .r     (in_r[l*RW +: RW]),
      .p     (in_p[l*RW +: RW]),
      .c     (out_c[l*LW +: LW])
    );
  end

endmodule
